// File: rtl/amm_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to Avalon-MM bridge.
package amm_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    WR_CMD  = 2'd2,
    WR_RESP = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/sc_fifo_ffmem.sv
// Single-clock FIFO built from flops, optional show-ahead output.
module sc_fifo_ffmem #(
  parameter int P_WIDTH     = 32,
  parameter int P_LOG2SIZE  = 2,
  parameter int P_SHOWAHEAD = 1
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               sclr,
  input  logic               wrreq,
  input  logic [P_WIDTH-1:0] data,
  input  logic               rdreq,
  output logic [P_WIDTH-1:0] q,
  output logic               empty
);

  localparam int DEPTH = 2 ** P_LOG2SIZE;

  logic [P_WIDTH-1:0]    mem [DEPTH];
  logic [P_LOG2SIZE-1:0] wr_ptr;
  logic [P_LOG2SIZE-1:0] rd_ptr;
  logic [P_LOG2SIZE:0]   count;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (count == '0);
  assign wr_en = wrreq & (count != (P_LOG2SIZE+1)'(DEPTH));
  assign rd_en = rdreq & ~empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  generate
    if (P_SHOWAHEAD != 0) begin : g_showahead
      assign q = mem[rd_ptr];
    end else begin : g_registered
      logic [P_WIDTH-1:0] q_reg;
      // Registered output updates on each pop.
      always_ff @(posedge clk or posedge aclr) begin
        if (aclr)       q_reg <= '0;
        else if (rd_en) q_reg <= mem[rd_ptr];
      end
      assign q = q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi4lite_amm_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge with buffered read responses.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | arbitrate between read and write requests
// RD_CMD  | m_read asserted until waitrequest drops
// WR_CMD  | m_write asserted until waitrequest drops
// WR_RESP | bvalid held until bready
module axi4lite_amm_bridge
  import amm_bridge_pkg::*;
#(
  parameter int P_SEL_BIT = 16,
  parameter int P_LOG2RD  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        m_portsel,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  output logic        m_read,
  output logic        m_write,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid
);

  localparam int RD_DEPTH = 2 ** P_LOG2RD;

  state_t            state;
  state_t            next_state;
  logic              rd_grant;
  logic              wr_grant;
  logic              rd_req;
  logic              wr_req;
  logic              r_hs;
  logic              fifo_empty;
  logic [P_LOG2RD:0] rd_cnt;
  // Set after a read grant so the next contested cycle goes to the write;
  // resets low so the very first contest goes to the read.
  logic              wr_prio;

  assign rd_req  = arvalid & (rd_cnt < (P_LOG2RD+1)'(RD_DEPTH));
  assign wr_req  = awvalid & wvalid;
  assign arready = rd_grant;
  assign awready = wr_grant;
  assign wready  = wr_grant;
  assign bvalid  = (state == WR_RESP);
  assign bresp   = RESP_OKAY;
  assign rvalid  = ~fifo_empty;
  assign rresp   = RESP_OKAY;
  assign r_hs    = rvalid & rready;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic and channel arbitration.
  always_comb begin
    next_state = state;
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && wr_req) begin
          if (wr_prio) wr_grant = 1'b1;
          else         rd_grant = 1'b1;
        end else if (rd_req) begin
          rd_grant = 1'b1;
        end else if (wr_req) begin
          wr_grant = 1'b1;
        end
        if (rd_grant)      next_state = RD_CMD;
        else if (wr_grant) next_state = WR_CMD;
      end
      RD_CMD:  if (!m_waitrequest) next_state = IDLE;
      WR_CMD:  if (!m_waitrequest) next_state = WR_RESP;
      WR_RESP: if (bready)         next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered Avalon command; held while waitrequest is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_portsel    <= 1'b0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_writedata  <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      wr_prio      <= 1'b0;
    end else begin
      if (rd_grant) begin
        m_address    <= araddr;
        m_byteenable <= 4'hF;
        m_portsel    <= araddr[P_SEL_BIT];
        m_read       <= 1'b1;
        wr_prio      <= 1'b1;
      end else if (wr_grant) begin
        m_address    <= awaddr;
        m_writedata  <= wdata;
        m_byteenable <= wstrb;
        m_portsel    <= awaddr[P_SEL_BIT];
        m_write      <= 1'b1;
        wr_prio      <= 1'b0;
      end
      if (state == RD_CMD && !m_waitrequest) m_read  <= 1'b0;
      if (state == WR_CMD && !m_waitrequest) m_write <= 1'b0;
    end
  end

  // Outstanding read count; capped by the read request qualifier.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt <= '0;
    end else begin
      case ({rd_grant, r_hs})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  sc_fifo_ffmem #(
    .P_WIDTH    (32),
    .P_LOG2SIZE (P_LOG2RD),
    .P_SHOWAHEAD(1)
  ) u_rd_buf (
    .clk  (clk),
    .aclr (~resetn),
    .sclr (1'b0),
    .wrreq(m_readdatavalid),
    .data (m_readdata),
    .rdreq(r_hs),
    .q    (rdata),
    .empty(fifo_empty)
  );

endmodule

// File: doc/axi4lite_amm_bridge.md
# axi4lite_amm_bridge

AXI4-Lite slave to Avalon-MM master bridge that drives the upstream side of the 1-to-2 Avalon-MM port multiplexer. It converts AXI4-Lite read and write transactions into single Avalon-MM commands and derives the port-select bit from the address. Read responses are buffered so that AXI `rready` backpressure never stalls Avalon `readdatavalid`. Outstanding reads are capped at the buffer depth, which also keeps the downstream response-order queue within its 4-deep limit.

## Interface
Parameters:
- `P_SEL_BIT`, 16: address bit index driving `m_portsel` (0 selects port 0, 1 selects port 1).
- `P_LOG2RD`, 2: read response buffer holds 2**P_LOG2RD entries; also the maximum number of outstanding reads. Must be ≤ 2.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: AXI write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: AXI write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: AXI write response channel.
- `araddr` in 32, `arvalid` in 1, `arready` out 1: AXI read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: AXI read data channel.
- `m_portsel` out 1, `m_address` out 32, `m_byteenable` out 4, `m_writedata` out 32, `m_read` out 1, `m_write` out 1: Avalon command outputs, all registered.
- `m_waitrequest` in 1, `m_readdata` in 32, `m_readdatavalid` in 1: Avalon response inputs.

## Operation
- FSM states:
  - `IDLE`: evaluates requests.
  - `RD_CMD`: asserts `m_read` until the command is accepted.
  - `WR_CMD`: asserts `m_write` until the command is accepted.
  - `WR_RESP`: holds `bvalid` until `bready`.
- In `IDLE`, a read request is `arvalid & (rd_cnt < 2**P_LOG2RD)`. A write request is `awvalid & wvalid`; AW and W are accepted together only.
- When both are requested, grant the channel not granted last (1-bit `last_wr` flag, reset 0, so a read wins first). Otherwise grant whichever is requested.
- Read grant:
  - Pulse `arready` for one cycle.
  - Register `m_address=araddr`, `m_byteenable=4'hF`, `m_portsel=araddr[P_SEL_BIT]`.
  - Go to `RD_CMD`.
- Write grant:
  - Pulse `awready` and `wready` in the same cycle.
  - Register address, `wdata`, `wstrb`, and portsel.
  - Go to `WR_CMD`.
- `RD_CMD` / `WR_CMD`: when `m_waitrequest` is low, drop `m_read`/`m_write` on the next edge. The read path returns to `IDLE`; the write path goes to `WR_RESP`.
- While `m_waitrequest` is high, all `m_*` outputs are held stable.
- `WR_RESP`: `bvalid=1`, `bresp=2'b00`. On `bready`, go to `IDLE`.
- Read buffer: show-ahead FIFO, 32 bits wide.
  - Written on `m_readdatavalid`; popped on `rvalid & rready`.
  - `rvalid = ~empty`, `rdata` = FIFO head, `rresp` = 2'b00.
- `rd_cnt` (P_LOG2RD+1 bits):
  - +1 on the `arready` pulse, −1 on the R handshake, unchanged when both occur in the same cycle.
  - It therefore never exceeds the FIFO depth, so the FIFO cannot overflow.
- Responses are never errors. A `m_readdatavalid` with `rd_cnt==0` is a protocol violation and is not handled.

## Timing
- Reset values:
  - All `*ready`, `bvalid`, `m_read`, `m_write`, `m_portsel`: 0.
  - `m_address`, `m_writedata`: 0. `m_byteenable`: 0.
  - `rd_cnt`: 0. FSM: `IDLE`. FIFO: empty, so `rvalid=0`.
- The `arready`/`awready` pulse occurs in cycle N; `m_read`/`m_write` is high from N+1. With zero wait states, the command completes at N+1 and `IDLE` is re-entered at N+2.
- Read throughput is at most one command per 2 cycles.
- `m_readdatavalid` in cycle M gives `rvalid` in M+1.
- Write: with zero wait states, `bvalid` is first high at N+2. The earliest new grant is the cycle after the `bready` handshake.
- Reset asserted mid-transaction: all state clears immediately. Buffered and in-flight responses are discarded; downstream must be reset together.

## Structure
- `amm_bridge_pkg`: FSM state enum and the `RESP_OKAY=2'b00` constant.
- One sub-module: `sc_fifo_ffmem` for the read buffer, configured with `P_WIDTH=32`, `P_LOG2SIZE=P_LOG2RD`, `P_SHOWAHEAD=1`.
  - `aclr` is driven from `~resetn`; `sclr` is tied to 0.

## Test plan
- Single write to addr 0x0001_0004, wdata 0xDEAD_BEEF, wstrb 4'b0011, zero waitrequest → `m_write` high for one cycle with `m_portsel=1`, `m_byteenable=4'b0011`; `bvalid` two cycles after `awready`; `bresp=0`.
- Read from addr 0x0000_0010 with waitrequest held for 3 cycles → `m_read` high for 4 cycles and command outputs stable throughout; readdata 0x1234_5678 returned on `rdata` one cycle after `m_readdatavalid`.
- `rready=0`, five back-to-back reads → exactly 4 `arready` pulses, then `arready` stays low. Release `rready` → 4 responses in order, then the 5th read is accepted.
- `arvalid`, `awvalid` and `wvalid` asserted continuously → grants alternate R, W, R, W.
- Assert `resetn` low while in `WR_CMD` with waitrequest high → `m_write`, `bvalid` and `rvalid` are 0 in the same cycle and `rd_cnt` is 0.
